synchro_bus_monitor: RTL and testbench



---
 rtl/synchro_bus_monitor.sv | 94 +++++++++
 tb/tb_synchro_bus_monitor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/synchro_bus_monitor.sv
// Receive-side monitor for a synchro_register bus: classifies each BUS sample,
// debounces the class over STABLE samples and reports levels, entry events and counts.
module synchro_bus_monitor #(
  parameter int N      = 4,
  parameter int STABLE = 3,
  parameter int CW     = 8
)(
  input  logic          CLK,
  input  logic          RESET,
  input  logic [N-1:0]  BUS,
  output logic          IS_ZEROES,
  output logic          IS_ONES,
  output logic          MIXED,
  output logic          ZEROES_EVT,
  output logic          ONES_EVT,
  output logic [CW-1:0] ZEROES_CNT,
  output logic [CW-1:0] ONES_CNT
);
  localparam int RW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {ST_UNK, ST_ZERO, ST_ONE, ST_MIX} state_t;
  typedef enum logic [1:0] {C_ZERO, C_ONE, C_MIX} cls_t;

  logic [N-1:0] bus_q;
  logic         smp_vld;
  cls_t         cls, run_cls;
  logic [RW-1:0] run, run_nxt;
  state_t       state, tgt;

  always_comb begin
    cls = C_MIX;
    if (&bus_q)      cls = C_ONE;
    else if (~|bus_q) cls = C_ZERO;
  end

  always_comb begin
    tgt = ST_MIX;
    case (cls)
      C_ZERO:  tgt = ST_ZERO;
      C_ONE:   tgt = ST_ONE;
      default: tgt = ST_MIX;
    endcase
  end

  // Run length including the sample currently in bus_q; the FSM acts on this
  // same edge so a report lands on the STABLE-th edge after the first sample.
  always_comb begin
    run_nxt = '0;
    if (smp_vld) begin
      if (run != '0 && cls == run_cls)
        run_nxt = (run == RW'(STABLE)) ? run : run + RW'(1);
      else
        run_nxt = RW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bus_q      <= '0;
      smp_vld    <= 1'b0;
      run        <= '0;
      run_cls    <= C_ZERO;
      state      <= ST_UNK;
      IS_ZEROES  <= 1'b0;
      IS_ONES    <= 1'b0;
      MIXED      <= 1'b0;
      ZEROES_EVT <= 1'b0;
      ONES_EVT   <= 1'b0;
      ZEROES_CNT <= '0;
      ONES_CNT   <= '0;
    end else begin
      bus_q      <= BUS;
      smp_vld    <= 1'b1;
      run        <= run_nxt;
      run_cls    <= cls;
      ZEROES_EVT <= 1'b0;
      ONES_EVT   <= 1'b0;
      if (run_nxt == RW'(STABLE) && state != tgt) begin
        state     <= tgt;
        IS_ZEROES <= (tgt == ST_ZERO);
        IS_ONES   <= (tgt == ST_ONE);
        MIXED     <= (tgt == ST_MIX);
        if (tgt == ST_ZERO) begin
          ZEROES_EVT <= 1'b1;
          if (ZEROES_CNT != '1) ZEROES_CNT <= ZEROES_CNT + CW'(1);
        end
        if (tgt == ST_ONE) begin
          ONES_EVT <= 1'b1;
          if (ONES_CNT != '1) ONES_CNT <= ONES_CNT + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_synchro_bus_monitor.sv
// Scoreboard bench: stimulus queues expected entry events, a monitor pops them on each EVT pulse.
module tb_synchro_bus_monitor;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] BUS = 4'b1111;

  logic       is_z, is_o, mix, z_evt, o_evt;
  logic [7:0] z_cnt, o_cnt;
  logic       is_z2, is_o2, mix2, z_evt2, o_evt2;
  logic [1:0] z_cnt2, o_cnt2;

  synchro_bus_monitor #(.N(4), .STABLE(3), .CW(8)) dut (
    .CLK(CLK), .RESET(RESET), .BUS(BUS),
    .IS_ZEROES(is_z), .IS_ONES(is_o), .MIXED(mix),
    .ZEROES_EVT(z_evt), .ONES_EVT(o_evt),
    .ZEROES_CNT(z_cnt), .ONES_CNT(o_cnt)
  );

  synchro_bus_monitor #(.N(4), .STABLE(3), .CW(2)) dut2 (
    .CLK(CLK), .RESET(RESET), .BUS(BUS),
    .IS_ZEROES(is_z2), .IS_ONES(is_o2), .MIXED(mix2),
    .ZEROES_EVT(z_evt2), .ONES_EVT(o_evt2),
    .ZEROES_CNT(z_cnt2), .ONES_CNT(o_cnt2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit ones;
    int o8, z8, o2, z2, at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic expect_evt(input bit ones, input int o8, input int z8,
                            input int o2, input int z2, input int at);
    exp_t x;
    x.ones = ones; x.o8 = o8; x.z8 = z8; x.o2 = o2; x.z2 = z2; x.at = at;
    q.push_back(x);
  endtask

  // Called at a negedge: value is sampled by the next n rising edges.
  task automatic hold(input logic [3:0] v, input int n);
    BUS = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_all_clear(input string name);
    chk({name, "_lvl"}, {is_z, is_o, mix, z_evt, o_evt}, 0);
    chk({name, "_cnt"}, {z_cnt, o_cnt}, 0);
    chk({name, "_cw2"}, {is_z2, is_o2, mix2, z_evt2, o_evt2, z_cnt2, o_cnt2}, 0);
  endtask

  // Monitor: every entry pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (!RESET && (z_evt || o_evt)) begin
      if (q.size() == 0) chk("unexpected_evt", {z_evt, o_evt}, 0);
      else begin
        e = q.pop_front();
        chk("evt_kind",     {z_evt, o_evt}, e.ones ? 1 : 2);
        chk("evt_cycle",    cyc, e.at);
        chk("evt_level",    {is_z, is_o, mix}, e.ones ? 2 : 4);
        chk("ones_cnt",     o_cnt, e.o8);
        chk("zeroes_cnt",   z_cnt, e.z8);
        chk("cw2_evt",      {z_evt2, o_evt2}, {z_evt, o_evt});
        chk("cw2_ones_cnt", o_cnt2, e.o2);
        chk("cw2_zero_cnt", z_cnt2, e.z2);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with BUS=1111
    repeat (5) @(negedge CLK);
    chk_all_clear("reset");
    RESET = 1'b0;

    // First report: 4th edge after release
    expect_evt(1, 1, 0, 1, 0, cyc + 4);
    hold(4'b1111, 5);
    chk("ones_level", {is_z, is_o, mix}, 2);

    // ONES -> ZEROES with no gap or overlap
    expect_evt(0, 1, 1, 1, 1, cyc + 4);
    BUS = 4'b0000;
    repeat (3) @(negedge CLK);
    chk("ones_held_before_switch", {is_z, is_o, mix}, 2);
    repeat (2) @(negedge CLK);

    // Glitch filter: 2x1111, 1x0101, then 1111
    hold(4'b1111, 2);
    chk("glitch_a_level", {is_z, is_o, mix}, 4);
    hold(4'b0101, 1);
    chk("glitch_b_level", {is_z, is_o, mix}, 4);
    expect_evt(1, 2, 1, 2, 1, cyc + 4);
    BUS = 4'b1111;
    repeat (3) @(negedge CLK);
    chk("glitch_c_level", {is_z, is_o, mix}, 4);
    repeat (2) @(negedge CLK);

    // Mixed pattern: level only, no event, no count
    hold(4'b0110, 5);
    chk("mixed_level", {is_z, is_o, mix}, 1);
    chk("mixed_cnts",  {z_cnt, o_cnt}, {8'd1, 8'd2});
    expect_evt(1, 3, 1, 3, 1, cyc + 4);
    hold(4'b1111, 5);

    // Saturation: restart from reset, 5 ones/zeroes entries
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    chk_all_clear("reset2");
    RESET = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      expect_evt(1, i, i - 1, (i > 3) ? 3 : i, (i - 1 > 3) ? 3 : i - 1, cyc + 4);
      hold(4'b1111, 4);
      expect_evt(0, i, i, (i > 3) ? 3 : i, (i > 3) ? 3 : i, cyc + 4);
      hold(4'b0000, 4);
    end

    // Async reset mid-run after 2 of 3 ones samples
    hold(4'b1111, 2);
    #3 RESET = 1'b1;
    #1 chk_all_clear("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    expect_evt(1, 1, 0, 1, 0, cyc + 4);
    hold(4'b1111, 5);

    repeat (3) @(negedge CLK);
    chk("pending_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
